mem_access_responder: RTL and testbench

//  Memory-side responder for the 3-bit memory-control field (bits [8:6]) of the microcoded

---
 rtl/mem_access_responder_if.sv | 47 ++++
 rtl/mem_access_responder.sv | 214 +++++++++++++++++++++
 tb/tb_mem_access_responder.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_responder_if.sv
// ---------------------------------------------------------------------------
// mem_access_responder_if
//   Bundles the command side (control store / AR / DR) and the RAM side of
//   the memory-access responder.
//
//   Command side : cmd_valid, mem_ctrl[2:0], ar_addr, dr_wdata in;
//                  ir_data, dr_rdata, ir_valid, dr_valid, busy, done, err out.
//   RAM side     : ram_en, ram_we, ram_addr, ram_wdata out; ram_rdata in.
//
//   slave  : the responder itself.
//   master : the environment (sequencer plus image RAM).
// ---------------------------------------------------------------------------
interface mem_access_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic [2:0]        mem_ctrl;
  logic [ADDR_W-1:0] ar_addr;
  logic [DATA_W-1:0] dr_wdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic [DATA_W-1:0] ir_data;
  logic [DATA_W-1:0] dr_rdata;
  logic              ir_valid;
  logic              dr_valid;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  cmd_valid, mem_ctrl, ar_addr, dr_wdata, ram_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    output ir_data, dr_rdata, ir_valid, dr_valid, busy, done, err
  );

  modport master (
    output cmd_valid, mem_ctrl, ar_addr, dr_wdata, ram_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    input  ir_data, dr_rdata, ir_valid, dr_valid, busy, done, err
  );
endinterface

// File: rtl/mem_access_responder.sv
// ---------------------------------------------------------------------------
// mem_access_responder
//   Memory-side responder for the 3-bit memory-control field of the
//   microcoded control word (100 = instruction fetch, 010 = data read,
//   001 = data write). One command is accepted at a time; the responder
//   drives a synchronous image RAM with a fixed read latency, returns the
//   fetched/read byte and holds busy so the sequencer stalls until done.
//
//   Parameters
//     ADDR_W  address width (AR / RAM address)
//     DATA_W  data width (DR / RAM word)
//     DEPTH   number of valid RAM words; addresses >= DEPTH raise err
//     RD_LAT  RAM read latency in clocks, 1..7
//
//   Ports
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  mem_access_responder_if.slave
//            cmd_valid/mem_ctrl/ar_addr/dr_wdata : command in (sampled in IDLE)
//            ram_en/ram_we/ram_addr/ram_wdata    : RAM request (1-cycle pulse)
//            ram_rdata                           : RAM read data
//            ir_data/ir_valid                    : fetched instruction byte
//            dr_rdata/dr_valid                   : data-read result
//            busy/done/err                       : status (err is sticky)
//
//   Timing (command accepted on cycle T):
//     write            : ram_en at T+1, done at T+2
//     read / fetch     : ram_en at T+1, data latched at T+1+RD_LAT,
//                        done + valid at T+2+RD_LAT
//     illegal / range  : no RAM access, done at T+2, err set
// ---------------------------------------------------------------------------
module mem_access_responder #(
  parameter int          ADDR_W = 16,
  parameter int          DATA_W = 8,
  parameter int unsigned DEPTH  = 65536,
  parameter int          RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_access_responder_if.slave bus
);

  // Range limit widened by one bit so DEPTH == 2**ADDR_W fits and the
  // unsigned compare is then always true (no range errors).
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [2:0]      RD_LAT_C  = 3'(RD_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    K_WRITE = 2'd0,
    K_READ  = 2'd1,
    K_FETCH = 2'd2
  } kind_e;

  state_e            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;

  kind_e             cmd_kind;
  logic              cmd_bad;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic [DATA_W-1:0] ir_data_q;
  logic [DATA_W-1:0] dr_rdata_q;
  logic              err_q;

  logic              accept;
  logic              in_range;
  logic              legal;
  logic              bad_in;
  kind_e             kind_in;

  logic              ram_en_c;
  logic              ram_we_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [DATA_W-1:0] ram_wdata_c;
  logic              lat_ir;
  logic              lat_dr;
  logic              done_c;
  logic              ir_valid_c;
  logic              dr_valid_c;

  // Exactly one of the three one-hot command encodings is legal.
  function automatic logic is_legal(input logic [2:0] c);
    return (c == 3'b100) || (c == 3'b010) || (c == 3'b001);
  endfunction

  function automatic kind_e decode_kind(input logic [2:0] c);
    kind_e k;
    case (c)
      3'b100:  k = K_FETCH;
      3'b010:  k = K_READ;
      default: k = K_WRITE;
    endcase
    return k;
  endfunction

  // ---- command acceptance ------------------------------------------------
  assign accept   = (state == IDLE) && bus.cmd_valid && (bus.mem_ctrl != 3'b000);
  assign legal    = is_legal(bus.mem_ctrl);
  assign in_range = ({1'b0, bus.ar_addr} < DEPTH_EXT);
  assign bad_in   = !legal || !in_range;
  assign kind_in  = decode_kind(bus.mem_ctrl);

  // ---- next state / outputs ----------------------------------------------
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ram_en_c    = 1'b0;
    ram_we_c    = 1'b0;
    ram_addr_c  = '0;
    ram_wdata_c = '0;
    lat_ir      = 1'b0;
    lat_dr      = 1'b0;
    done_c      = 1'b0;
    ir_valid_c  = 1'b0;
    dr_valid_c  = 1'b0;

    case (state)
      IDLE: begin
        if (accept) state_nxt = ISSUE;
      end

      ISSUE: begin
        if (cmd_bad) begin
          // Rejected command: spend the issue slot without touching RAM so
          // error completion keeps the same 2-cycle latency as a write.
          state_nxt = RESP;
        end else begin
          ram_en_c   = 1'b1;
          ram_addr_c = cmd_addr;
          if (cmd_kind == K_WRITE) begin
            ram_we_c    = 1'b1;
            ram_wdata_c = cmd_wdata;
            state_nxt   = RESP;
          end else begin
            cnt_nxt   = RD_LAT_C;
            state_nxt = WAIT;
          end
        end
      end

      WAIT: begin
        cnt_nxt = cnt - 3'd1;
        // cnt reaches 1 exactly RD_LAT cycles after ram_en, which is the
        // cycle the RAM presents valid read data.
        if (cnt == 3'd1) begin
          lat_ir    = (cmd_kind == K_FETCH);
          lat_dr    = (cmd_kind == K_READ);
          state_nxt = RESP;
        end
      end

      RESP: begin
        done_c     = 1'b1;
        ir_valid_c = !cmd_bad && (cmd_kind == K_FETCH);
        dr_valid_c = !cmd_bad && (cmd_kind == K_READ);
        state_nxt  = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // ---- control and result registers ---------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cmd_kind   <= K_WRITE;
      cmd_bad    <= 1'b0;
      err_q      <= 1'b0;
      ir_data_q  <= '0;
      dr_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cmd_kind <= kind_in;
        cmd_bad  <= bad_in;
        if (bad_in) err_q <= 1'b1;
      end
      if (lat_ir) ir_data_q  <= bus.ram_rdata;
      if (lat_dr) dr_rdata_q <= bus.ram_rdata;
    end
  end

  // ---- captured command payload -------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_addr  <= bus.ar_addr;
      cmd_wdata <= bus.dr_wdata;
    end
  end

  assign bus.ram_en    = ram_en_c;
  assign bus.ram_we    = ram_we_c;
  assign bus.ram_addr  = ram_addr_c;
  assign bus.ram_wdata = ram_wdata_c;
  assign bus.ir_data   = ir_data_q;
  assign bus.dr_rdata  = dr_rdata_q;
  assign bus.ir_valid  = ir_valid_c;
  assign bus.dr_valid  = dr_valid_c;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_c;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_access_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_access_responder
//   Directed bench for mem_access_responder (DEPTH=1024, RD_LAT=2). The
//   bench plays sequencer and image RAM. A transaction-level model tracks
//   the active command and its cycle offset from acceptance, and derives
//   every expected output from the documented latencies; a forked process
//   compares the DUT against it on each falling edge. Literal expectations
//   pin the model for the main scenarios.
// ---------------------------------------------------------------------------
module tb_mem_access_responder;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_access_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    if (i == 0) return 8'h2F;
    return 8'(i) ^ 8'h5A;
  endfunction

  // ---- image RAM (environment) --------------------------------------------
  logic [7:0] ram [1024];
  logic       ram_init = 1'b0;
  logic [7:0] rd_p0, rd_p1;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
      ram_init <= 1'b1;
    end else if (bus.ram_en && bus.ram_we) begin
      ram[bus.ram_addr[9:0]] <= bus.ram_wdata;
    end
    // Off-slot cycles carry filler so a mistimed latch is visible.
    rd_p0 <= (bus.ram_en && !bus.ram_we) ? ram[bus.ram_addr[9:0]] : (8'hC3 ^ 8'(cyc));
    rd_p1 <= rd_p0;
  end
  assign bus.ram_rdata = rd_p1;

  // ---- transaction model ----------------------------------------------------
  typedef enum int {K_WR, K_RD, K_FE} kind_e;

  logic       m_active = 1'b0;
  int         m_t      = 0;
  kind_e      m_kind   = K_WR;
  logic       m_bad    = 1'b0;
  logic [15:0] m_addr;
  logic [7:0] m_data;
  logic [7:0] m_ir     = 8'h00;
  logic [7:0] m_dr     = 8'h00;
  logic       m_err    = 1'b0;
  logic [7:0] m_mem [1024];
  logic       m_init   = 1'b0;
  int         n_now;

  // n_now = k means the current cycle is T+k for an accept on cycle T.
  always_comb n_now = cyc - m_t + 1;

  function automatic int done_at();
    return (m_bad || m_kind == K_WR) ? 2 : 2 + RD_LAT;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_bad    <= 1'b0;
      m_ir     <= 8'h00;
      m_dr     <= 8'h00;
      m_err    <= 1'b0;
    end else if (m_active) begin
      if (!m_bad && m_kind != K_WR && n_now == 1 + RD_LAT) begin
        if (m_kind == K_RD) m_dr <= m_mem[m_addr[9:0]];
        else                m_ir <= m_mem[m_addr[9:0]];
      end
      if (n_now == done_at()) m_active <= 1'b0;
    end else if (bus.cmd_valid && bus.mem_ctrl != 3'b000) begin
      m_active <= 1'b1;
      m_t      <= cyc + 1;
      m_addr   <= bus.ar_addr;
      m_data   <= bus.dr_wdata;
      case (bus.mem_ctrl)
        3'b100:  m_kind <= K_FE;
        3'b010:  m_kind <= K_RD;
        default: m_kind <= K_WR;
      endcase
      if (!(bus.mem_ctrl inside {3'b100, 3'b010, 3'b001}) || int'(bus.ar_addr) >= DEPTH) begin
        m_bad <= 1'b1;
        m_err <= 1'b1;
      end else begin
        m_bad <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (!m_init) begin
      for (int i = 0; i < 1024; i++) m_mem[i] <= init_val(i);
      m_init <= 1'b1;
    end else if (!rst && m_active && !m_bad && m_kind == K_WR && n_now == 1) begin
      m_mem[m_addr[9:0]] <= m_data;
    end
  end

  // ---- checking -------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_cycle();
    logic e_en, e_done;
    e_en   = m_active && !m_bad && (n_now == 1);
    e_done = m_active && (n_now == done_at());
    chk("busy",     bus.busy,     m_active);
    chk("ram_en",   bus.ram_en,   e_en);
    chk("ram_we",   bus.ram_we,   e_en && m_kind == K_WR);
    if (e_en) chk("ram_addr", bus.ram_addr, m_addr);
    if (e_en && m_kind == K_WR) chk("ram_wdata", bus.ram_wdata, m_data);
    chk("done",     bus.done,     e_done);
    chk("ir_valid", bus.ir_valid, e_done && !m_bad && m_kind == K_FE);
    chk("dr_valid", bus.dr_valid, e_done && !m_bad && m_kind == K_RD);
    chk("ir_data",  bus.ir_data,  m_ir);
    chk("dr_rdata", bus.dr_rdata, m_dr);
    // The exact cycle err rises inside a rejected command is not pinned.
    if (!(m_active && m_bad && n_now == 1)) chk("err", bus.err, m_err);
  endtask

  // ---- stimulus helpers -----------------------------------------------------
  task automatic send(input logic [2:0] ctrl, input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #2;
    bus.cmd_valid = 1'b1;
    bus.mem_ctrl  = ctrl;
    bus.ar_addr   = a;
    bus.dr_wdata  = d;
    @(posedge clk); #2;
    bus.cmd_valid = 1'b0;
    bus.mem_ctrl  = 3'b000;
  endtask

  // Returns at the falling edge of the done cycle; n counts from T+1.
  task automatic wait_done(input string name, input int exp_n);
    int n;
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n = i;
        break;
      end
    end
    chk(name, n, exp_n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.mem_ctrl  = 3'b000;
    bus.ar_addr   = '0;
    bus.dr_wdata  = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy",  bus.busy,     0);
    chk("rst_done",  bus.done,     0);
    chk("rst_en",    bus.ram_en,   0);
    chk("rst_err",   bus.err,      0);
    chk("rst_ir",    bus.ir_data,  0);
    chk("rst_dr",    bus.dr_rdata, 0);
    rst = 1'b0;

    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    // Write then read back
    send(3'b001, 16'h0010, 8'hA5);
    wait_done("wr_lat", 2);
    chk("wr_nodv", bus.dr_valid, 0);
    send(3'b010, 16'h0010, 8'h00);
    wait_done("rd_lat", 4);
    chk("rd_data",  bus.dr_rdata, 8'hA5);
    chk("rd_valid", bus.dr_valid, 1);
    chk("model_dr", m_dr,         8'hA5);

    // Fetch from address 0
    send(3'b100, 16'h0000, 8'h00);
    wait_done("fe_lat", 4);
    chk("fe_data",  bus.ir_data,  8'h2F);
    chk("fe_valid", bus.ir_valid, 1);
    chk("fe_drhld", bus.dr_rdata, 8'hA5);

    // Last in-range address
    send(3'b001, 16'h03FF, 8'h3C);
    wait_done("top_wr_lat", 2);
    send(3'b010, 16'h03FF, 8'h00);
    wait_done("top_rd_lat", 4);
    chk("top_data", bus.dr_rdata, 8'h3C);
    chk("top_err",  bus.err,      0);

    // NOP in IDLE
    @(posedge clk); #2;
    bus.cmd_valid = 1'b1;
    bus.mem_ctrl  = 3'b000;
    @(posedge clk); #2;
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nop_busy", bus.busy, 0);
      chk("nop_done", bus.done, 0);
    end

    // New command held on cmd_valid while busy is ignored
    @(posedge clk); #2;
    bus.cmd_valid = 1'b1;
    bus.mem_ctrl  = 3'b010;
    bus.ar_addr   = 16'h0010;
    @(posedge clk); #2;
    bus.mem_ctrl  = 3'b001;
    bus.dr_wdata  = 8'h77;
    wait_done("hold_lat", 4);
    bus.cmd_valid = 1'b0;
    bus.mem_ctrl  = 3'b000;
    chk("hold_data", bus.dr_rdata, 8'hA5);
    send(3'b010, 16'h0010, 8'h00);
    wait_done("hold_rb_lat", 4);
    chk("hold_nowr", bus.dr_rdata, 8'hA5);

    // Illegal command
    send(3'b110, 16'h0020, 8'h00);
    wait_done("ill_lat", 2);
    chk("ill_err",  bus.err,      1);
    chk("ill_nodv", bus.dr_valid, 0);
    chk("ill_noiv", bus.ir_valid, 0);
    send(3'b100, 16'h0002, 8'h00);
    wait_done("after_ill_lat", 4);
    chk("err_sticky", bus.err,     1);
    chk("after_ill",  bus.ir_data, 8'h58);

    // Reset while waiting on read data
    send(3'b100, 16'h0001, 8'h00);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_busy", bus.busy,     0);
    chk("mid_done", bus.done,     0);
    chk("mid_iv",   bus.ir_valid, 0);
    chk("mid_err",  bus.err,      0);
    chk("mid_ir",   bus.ir_data,  0);
    chk("mid_dr",   bus.dr_rdata, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_done", bus.done, 0);
    end
    send(3'b100, 16'h0000, 8'h00);
    wait_done("post_rst_lat", 4);
    chk("post_rst_ir", bus.ir_data, 8'h2F);
    send(3'b010, 16'h0010, 8'h00);
    wait_done("persist_lat", 4);
    chk("persist", bus.dr_rdata, 8'hA5);

    // First out-of-range address and the top of the address space
    send(3'b010, 16'h0400, 8'h00);
    wait_done("oor_lat", 2);
    chk("oor_err",  bus.err,      1);
    chk("oor_nodv", bus.dr_valid, 0);
    chk("oor_dr",   bus.dr_rdata, 8'hA5);
    send(3'b001, 16'hFFFF, 8'h11);
    wait_done("oor2_lat", 2);
    chk("oor2_err", bus.err, 1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
